// File: rtl/seq_operand_tx.sv
// Serialises one captured operand pair, MSB first, to an external bit-serial
// comparator and registers the comparator's one-hot verdict when the pair is done.
module seq_operand_tx #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         ready,
  output logic         cmp_clr,
  output logic         a_bit,
  output logic         b_bit,
  output logic         bit_valid,
  input  logic [2:0]   leg_in,
  output logic [2:0]   result,
  output logic         done
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    result_q, result_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          cnt_d   = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_SHIFT;
      S_SHIFT: begin
        a_d = {a_q[W-2:0], 1'b0};
        b_d = {b_q[W-2:0], 1'b0};
        // Hold on the last bit so the counter never wraps inside a transfer.
        if (cnt_q == CW'(W - 1)) begin
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        // A malformed (non one-hot) verdict is recorded as "no verdict".
        result_d = (leg_in inside {3'b001, 3'b010, 3'b100}) ? leg_in : 3'b000;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ready     = (state_q == S_IDLE);
  assign cmp_clr   = (state_q == S_CLEAR);
  assign bit_valid = (state_q == S_SHIFT);
  assign a_bit     = bit_valid & a_q[W-1];
  assign b_bit     = bit_valid & b_q[W-1];
  assign done      = (state_q == S_DONE);
  assign result    = result_q;

endmodule
